// File: rtl/mem_wb_writeback_pkg.sv
// Shared constants and load-op encoding for the MEM/WB writeback slice.
package mem_wb_writeback_pkg;

   localparam int REG_DATA_W = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic RST_ENABLE    = 1'b0;
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   typedef enum logic [2:0] {
      LD_LB  = 3'd0,
      LD_LBU = 3'd1,
      LD_LH  = 3'd2,
      LD_LHU = 3'd3,
      LD_LW  = 3'd4,
      LD_LWL = 3'd5,
      LD_LWR = 3'd6
   } load_op_e;

endpackage

// File: rtl/mem_wb_writeback_if.sv
// MEM-stage slot entering WB and the registered regfile / HI-LO write ports leaving it.
interface mem_wb_writeback_if
   import mem_wb_writeback_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int CNT_W  = 32
);
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_waddr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_is_load;
   logic [2:0]        mem_load_op;
   logic [1:0]        mem_addr_lo;
   logic [DATA_W-1:0] mem_load_data;
   logic [DATA_W-1:0] mem_rt_data;
   logic              mem_whilo;
   logic [DATA_W-1:0] mem_hi;
   logic [DATA_W-1:0] mem_lo;

   logic [ADDR_W-1:0] wb_waddr;
   logic [DATA_W-1:0] wb_wdata;
   logic              wb_we;
   logic              wb_whilo;
   logic [DATA_W-1:0] wb_hi;
   logic [DATA_W-1:0] wb_lo;
   logic [CNT_W-1:0]  wb_retire_cnt;

   modport master (
      output mem_valid, mem_waddr, mem_we, mem_wdata, mem_is_load, mem_load_op,
             mem_addr_lo, mem_load_data, mem_rt_data, mem_whilo, mem_hi, mem_lo,
      input  wb_waddr, wb_wdata, wb_we, wb_whilo, wb_hi, wb_lo, wb_retire_cnt
   );

   modport slave (
      input  mem_valid, mem_waddr, mem_we, mem_wdata, mem_is_load, mem_load_op,
             mem_addr_lo, mem_load_data, mem_rt_data, mem_whilo, mem_hi, mem_lo,
      output wb_waddr, wb_wdata, wb_we, wb_whilo, wb_hi, wb_lo, wb_retire_cnt
   );
endinterface

// File: rtl/mem_wb_writeback_load_align.sv
// Big-endian load formatter: picks the addressed byte/half/word and merges LWL/LWR with old rt.
module load_align
   import mem_wb_writeback_pkg::*;
(
   input  logic [2:0]            load_op,
   input  logic [1:0]            addr_lo,
   input  logic [REG_DATA_W-1:0] mem_data,
   input  logic [REG_DATA_W-1:0] rt_data,
   output logic [REG_DATA_W-1:0] aligned
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = mem_data[31:24];
      case (addr_lo)
         2'd0: byte_sel = mem_data[31:24];
         2'd1: byte_sel = mem_data[23:16];
         2'd2: byte_sel = mem_data[15:8];
         2'd3: byte_sel = mem_data[7:0];
      endcase
      // addr_lo[0] is deliberately ignored for halfwords
      half_sel = addr_lo[1] ? mem_data[15:0] : mem_data[31:16];

      aligned = '0;
      case (load_op)
         LD_LB:  aligned = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU: aligned = {24'd0, byte_sel};
         LD_LH:  aligned = {{16{half_sel[15]}}, half_sel};
         LD_LHU: aligned = {16'd0, half_sel};
         LD_LW:  aligned = mem_data;
         LD_LWL: begin
            case (addr_lo)
               2'd0: aligned = mem_data;
               2'd1: aligned = {mem_data[23:0], rt_data[7:0]};
               2'd2: aligned = {mem_data[15:0], rt_data[15:0]};
               2'd3: aligned = {mem_data[7:0],  rt_data[23:0]};
            endcase
         end
         LD_LWR: begin
            case (addr_lo)
               2'd0: aligned = {rt_data[31:8],  mem_data[31:24]};
               2'd1: aligned = {rt_data[31:16], mem_data[31:16]};
               2'd2: aligned = {rt_data[31:24], mem_data[31:8]};
               2'd3: aligned = mem_data;
            endcase
         end
         default: aligned = '0;
      endcase
   end
endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register: formats load data, applies flush/stall priority, counts retirements.
module mem_wb_writeback
   import mem_wb_writeback_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int CNT_W  = 32
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_mem,
   input  logic               stall_wb,
   input  logic               flush,
   mem_wb_writeback_if.slave  bus
);
   logic [DATA_W-1:0] aligned;

   load_align u_load_align (
      .load_op  (bus.mem_load_op),
      .addr_lo  (bus.mem_addr_lo),
      .mem_data (bus.mem_load_data),
      .rt_data  (bus.mem_rt_data),
      .aligned  (aligned)
   );

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         bus.wb_waddr      <= '0;
         bus.wb_wdata      <= '0;
         bus.wb_we         <= WRITE_DISABLE;
         bus.wb_whilo      <= WRITE_DISABLE;
         bus.wb_hi         <= '0;
         bus.wb_lo         <= '0;
         bus.wb_retire_cnt <= '0;
      end else if (flush || (stall_mem && !stall_wb)) begin
         bus.wb_waddr <= '0;
         bus.wb_wdata <= '0;
         bus.wb_we    <= WRITE_DISABLE;
         bus.wb_whilo <= WRITE_DISABLE;
         bus.wb_hi    <= '0;
         bus.wb_lo    <= '0;
      end else if (!stall_wb) begin
         // writes to $0 die here so the regfile never has to filter them
         bus.wb_waddr      <= bus.mem_waddr;
         bus.wb_wdata      <= bus.mem_is_load ? aligned : bus.mem_wdata;
         bus.wb_we         <= (bus.mem_valid && (bus.mem_we == WRITE_ENABLE) &&
                               (bus.mem_waddr != '0)) ? WRITE_ENABLE : WRITE_DISABLE;
         bus.wb_whilo      <= (bus.mem_valid && (bus.mem_whilo == WRITE_ENABLE)) ?
                              WRITE_ENABLE : WRITE_DISABLE;
         bus.wb_hi         <= bus.mem_hi;
         bus.wb_lo         <= bus.mem_lo;
         bus.wb_retire_cnt <= bus.wb_retire_cnt + CNT_W'(bus.mem_valid);
      end
   end
endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench: stimulus queues hand-computed WB outputs, a negedge monitor pops and compares.
module tb_mem_wb_writeback;
   import mem_wb_writeback_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, stall_mem, stall_wb, flush;

   mem_wb_writeback_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
   mem_wb_writeback_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

   assign bus4.mem_valid     = bus.mem_valid;
   assign bus4.mem_waddr     = bus.mem_waddr;
   assign bus4.mem_we        = bus.mem_we;
   assign bus4.mem_wdata     = bus.mem_wdata;
   assign bus4.mem_is_load   = bus.mem_is_load;
   assign bus4.mem_load_op   = bus.mem_load_op;
   assign bus4.mem_addr_lo   = bus.mem_addr_lo;
   assign bus4.mem_load_data = bus.mem_load_data;
   assign bus4.mem_rt_data   = bus.mem_rt_data;
   assign bus4.mem_whilo     = bus.mem_whilo;
   assign bus4.mem_hi        = bus.mem_hi;
   assign bus4.mem_lo        = bus.mem_lo;

   mem_wb_writeback #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush), .bus(bus)
   );

   mem_wb_writeback #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush), .bus(bus4)
   );

   logic [2:0]  la_op;
   logic [1:0]  la_a;
   logic [31:0] la_mem, la_rt, la_out;

   load_align u_align (
      .load_op(la_op), .addr_lo(la_a), .mem_data(la_mem), .rt_data(la_rt), .aligned(la_out)
   );

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_slot   = 0;

   task automatic idle();
      bus.mem_valid     = 1'b0;
      bus.mem_waddr     = '0;
      bus.mem_we        = 1'b0;
      bus.mem_wdata     = '0;
      bus.mem_is_load   = 1'b0;
      bus.mem_load_op   = '0;
      bus.mem_addr_lo   = '0;
      bus.mem_load_data = '0;
      bus.mem_rt_data   = '0;
      bus.mem_whilo     = 1'b0;
      bus.mem_hi        = '0;
      bus.mem_lo        = '0;
      stall_mem         = 1'b0;
      stall_wb          = 1'b0;
      flush             = 1'b0;
   endtask

   task automatic tick(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] cnt);
      exp_t e;
      @(posedge clk);
      e.we = we; e.waddr = waddr; e.wdata = wdata; e.whilo = whilo;
      e.hi = hi; e.lo = lo; e.cnt = cnt;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] exp_d,
                       input logic [31:0] cnt);
      bus.mem_load_op = op;
      bus.mem_addr_lo = a;
      tick(1'b1, 5'd3, exp_d, 1'b0, 32'h0, 32'h0, cnt);
   endtask

   task automatic check_align(input logic [2:0] op, input logic [1:0] a, input logic [31:0] m,
                              input logic [31:0] r, input logic [31:0] exp_d);
      la_op = op; la_a = a; la_mem = m; la_rt = r;
      #1;
      n_checks++;
      if (la_out === exp_d) n_pass++;
      else $display("FAIL align op=%0d a=%0d: got %h want %h", op, a, la_out, exp_d);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_slot++;
            n_checks++;
            if (bus.wb_we === e.we && bus.wb_waddr === e.waddr && bus.wb_wdata === e.wdata &&
                bus.wb_whilo === e.whilo && bus.wb_hi === e.hi && bus.wb_lo === e.lo &&
                bus.wb_retire_cnt === e.cnt && bus4.wb_retire_cnt === e.cnt[3:0])
               n_pass++;
            else
               $display("FAIL slot%0d: got we=%b wa=%0d wd=%h whilo=%b hi=%h lo=%h cnt=%0d cnt4=%0d want we=%b wa=%0d wd=%h whilo=%b hi=%h lo=%h cnt=%0d cnt4=%0d",
                        n_slot, bus.wb_we, bus.wb_waddr, bus.wb_wdata, bus.wb_whilo, bus.wb_hi,
                        bus.wb_lo, bus.wb_retire_cnt, bus4.wb_retire_cnt, e.we, e.waddr, e.wdata,
                        e.whilo, e.hi, e.lo, e.cnt, e.cnt[3:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      idle();
      rst = 1'b0;

      check_align(LD_LB,  2'd1, 32'h80FF7F01, 32'h0, 32'hFFFFFFFF);
      check_align(LD_LBU, 2'd2, 32'h80FF7F01, 32'h0, 32'h0000007F);
      check_align(LD_LH,  2'd1, 32'h80FF7F01, 32'h0, 32'hFFFF80FF);
      check_align(LD_LW,  2'd3, 32'h80FF7F01, 32'h0, 32'h80FF7F01);
      check_align(LD_LWL, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'hAABBCCDD);
      check_align(LD_LWL, 2'd2, 32'hAABBCCDD, 32'h11223344, 32'hCCDD3344);
      check_align(LD_LWR, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h112233AA);
      check_align(LD_LWR, 2'd2, 32'hAABBCCDD, 32'h11223344, 32'h11AABBCC);
      check_align(3'd7,   2'd1, 32'hAABBCCDD, 32'h11223344, 32'h00000000);

      // reset holds everything at zero even with a write request present
      bus.mem_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_waddr = 5'd7; bus.mem_wdata = 32'hDEADBEEF;
      tick(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
      tick(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
      rst = 1'b1;
      tick(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 32'd1);

      bus.mem_waddr = 5'd0; bus.mem_wdata = 32'h00001234;
      tick(1'b0, 5'd0, 32'h00001234, 1'b0, 32'h0, 32'h0, 32'd2);

      bus.mem_waddr = 5'd3; bus.mem_wdata = 32'h0; bus.mem_is_load = 1'b1;
      bus.mem_load_data = 32'h80FF7F01;
      load(LD_LB,  2'd0, 32'hFFFFFF80, 32'd3);
      load(LD_LBU, 2'd0, 32'h00000080, 32'd4);
      load(LD_LB,  2'd3, 32'h00000001, 32'd5);
      load(LD_LH,  2'd0, 32'hFFFF80FF, 32'd6);
      load(LD_LHU, 2'd2, 32'h00007F01, 32'd7);

      bus.mem_load_data = 32'hAABBCCDD; bus.mem_rt_data = 32'h11223344;
      load(LD_LWL, 2'd1, 32'hBBCCDD44, 32'd8);
      load(LD_LWR, 2'd1, 32'h1122AABB, 32'd9);
      load(LD_LWL, 2'd3, 32'hDD223344, 32'd10);
      load(LD_LWR, 2'd3, 32'hAABBCCDD, 32'd11);
      load(3'd7,   2'd0, 32'h00000000, 32'd12);
      load(LD_LW,  2'd2, 32'hAABBCCDD, 32'd13);

      // A captured, then held by stall_wb while the MEM side changes
      bus.mem_is_load = 1'b0; bus.mem_waddr = 5'd9; bus.mem_wdata = 32'hA5A5A5A5;
      tick(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0, 32'd14);
      bus.mem_waddr = 5'd10; bus.mem_wdata = 32'h55555555; stall_wb = 1'b1;
      repeat (3) tick(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0, 32'd14);
      stall_wb = 1'b0; stall_mem = 1'b1;
      tick(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd14);
      stall_mem = 1'b0;
      tick(1'b1, 5'd10, 32'h55555555, 1'b0, 32'h0, 32'h0, 32'd15);
      flush = 1'b1; stall_wb = 1'b1;
      tick(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd15);
      flush = 1'b0; stall_wb = 1'b0;
      bus.mem_waddr = 5'd11; bus.mem_wdata = 32'h0BADF00D;
      tick(1'b1, 5'd11, 32'h0BADF00D, 1'b0, 32'h0, 32'h0, 32'd16);
      stall_mem = 1'b1; stall_wb = 1'b1;
      tick(1'b1, 5'd11, 32'h0BADF00D, 1'b0, 32'h0, 32'h0, 32'd16);
      stall_mem = 1'b0; stall_wb = 1'b0;

      bus.mem_we = 1'b0; bus.mem_waddr = 5'd0; bus.mem_wdata = 32'h0;
      bus.mem_whilo = 1'b1; bus.mem_hi = 32'h1; bus.mem_lo = 32'h2;
      tick(1'b0, 5'd0, 32'h0, 1'b1, 32'h1, 32'h2, 32'd17);
      bus.mem_valid = 1'b0; bus.mem_hi = 32'h0; bus.mem_lo = 32'h0;
      tick(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd17);

      // mid-stream reset, then walk the 4-bit counter through its wrap
      bus.mem_valid = 1'b1; bus.mem_we = 1'b1; bus.mem_whilo = 1'b0;
      bus.mem_waddr = 5'd5; bus.mem_wdata = 32'hFFFF;
      rst = 1'b0;
      tick(1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
      rst = 1'b1;
      bus.mem_waddr = 5'd1;
      for (int i = 1; i <= 16; i++) begin
         bus.mem_wdata = 32'(i);
         tick(1'b1, 5'd1, 32'(i), 1'b0, 32'h0, 32'h0, 32'(i));
      end

      idle();
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
